div_monitor: RTL and testbench
==============================

Name: div_monitor

Overview:
- Downstream checker for the divide-by-N clock dividers (divide3/divide5 style, ports rst/clk/q).
- Samples a divider's q output on the same clk that drives the divider.
- Measures its period and high time in clk cycles, declares lock after consecutive good periods, and counts errors.
- Used in simulation and as an on-chip health monitor for divided clocks.

Parameters:
N, 3, expected divide ratio (N >= 2)
CNT_W, 8, width of period/high counters (2^CNT_W > 2*N)
LOCK_CNT, 4, consecutive good periods needed to assert locked
ERR_W, 8, width of err_cnt

Ports:
clk  input  1  system clock; same clock that feeds the divider
rst  input  1  reset, asynchronous, active-high
en  input  1  monitor enable
div_in  input  1  divider output under test (q), synchronous to clk
period  output  CNT_W  last measured period in clk cycles; 0 = timeout marker
high_cnt  output  CNT_W  clk samples div_in was high in last period
period_valid  output  1  one-cycle pulse when period/high_cnt update
locked  output  1  LOCK_CNT consecutive good periods seen
lock_lost  output  1  sticky; set when a bad period or timeout occurs while locked
err_cnt  output  ERR_W  saturating count of bad periods and timeouts

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; state IDLE.
  - div_d=0; internal cnt, hcnt and good counters 0.
- Edge detect: rise = div_in & ~div_d, where div_d is div_in registered every cycle. No synchroniser.
- All outputs are registered and update on the posedge that samples the event.
- States:
  - IDLE: counters held at 0. en=1 -> SYNC.
  - SYNC: wait for rise. On rise: cnt=1, hcnt=1 -> MEASURE.
  - MEASURE: each cycle without rise: cnt+=1, hcnt+=div_in.
  - On rise in MEASURE or LOCKED:
    - period<=cnt, high_cnt<=hcnt, period_valid=1 for one cycle.
    - Restart the next period: cnt=1, hcnt=1.
  - LOCKED: counting identical to MEASURE.
- Good period:
  - cnt==N, and
  - hcnt==N/2 or hcnt==(N+1)/2 (integer division), covering 50% duty sampled on a single edge.
- On a good period: good counter +1, saturating at LOCK_CNT. Reaching LOCK_CNT -> locked=1, state LOCKED.
- On a bad period:
  - Good counter cleared; err_cnt+1, saturating at all-ones.
  - If in LOCKED: locked<=0, lock_lost<=1, state -> MEASURE.
- Timeout: cnt reaches 2*N with no rise.
  - period_valid=1, period=0, high_cnt=hcnt.
  - err_cnt+1; good counter cleared.
  - locked<=0, and lock_lost<=1 if locked was set; state -> SYNC.
- en=0 in any state:
  - Next state IDLE; locked<=0; counters cleared; period_valid=0.
  - period, high_cnt, err_cnt and lock_lost hold.
  - en has priority over a simultaneous rise or timeout.
- lock_lost and err_cnt clear only on rst.
- Reset mid-period discards the partial measurement; no period_valid is issued.
- Counter widths: cnt and hcnt never exceed 2*N, so no wrap occurs within CNT_W.

Optional Feature:
DIV_MON_DUTY_CHECK_EN
- Defined: hcnt is tracked, high_cnt is driven, and the duty condition is part of the good-period test.
- Undefined:
  - Only cnt==N is checked.
  - hcnt logic is removed and high_cnt is tied to 0.
  - All other behaviour is identical.

Test Plan:
1. N=3, rst 1->0 at 2 cycles, en=1, div_in pattern 1,1,0 repeating -> period_valid every 3 cycles with period=3, high_cnt=2; locked=1 on the 4th valid; err_cnt=0.
2. N=5, div_in pattern 1,1,0,0,0 repeating -> period=5, high_cnt=2, locked after 4 periods. Then one period of 4 (1,1,0,0) -> locked=0 on that valid, lock_lost=1, err_cnt=1; relock after 4 further good periods, lock_lost still 1.
3. N=3, locked, then div_in held 0 -> 6 cycles after the last rise: period_valid with period=0, err_cnt+1, locked=0, state SYNC; restoring the pattern relocks after 4 periods.
4. N=5, pattern 1,1,1,1,0:
   - Macro defined: high_cnt=4, each period bad, err_cnt increments every 5 cycles, locked stays 0.
   - Macro undefined: locked after 4 periods, high_cnt=0.
5. Assert rst for 1 cycle mid-period while locked -> all outputs 0 immediately (async), no period_valid; after release, first valid occurs one full period after the first rise.
6. en dropped for 3 cycles while locked, coinciding with a rise -> no period_valid, locked=0, err_cnt unchanged. Re-enable -> SYNC, relock after 4 periods. Force 300 timeouts with ERR_W=8 -> err_cnt saturates at 255.

Source files
------------

// File: rtl/div_monitor.sv
// Period/duty checker for divide-by-N clock outputs sampled on the divider's own clock.
// Optional duty-cycle tracking is enabled by defining DIV_MON_DUTY_CHECK_EN.
module div_monitor #(
   parameter int N        = 3,
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_cnt,
   output logic             period_valid,
   output logic             locked,
   output logic             lock_lost,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] N_C     = CNT_W'(N);
   localparam logic [CNT_W-1:0] TWO_N   = CNT_W'(2 * N);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [GW-1:0]    LOCK_C  = GW'(LOCK_CNT);

   typedef enum logic [1:0] {IDLE, SYNC, MEASURE, LOCKED} state_t;

   state_t           state_reg;
   logic             div_d_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [GW-1:0]    good_reg;

   logic             rise;
   logic             active;
   logic             period_end;
   logic             timeout;
   logic             start;
   logic             duty_ok;
   logic             good_period;
   logic [GW-1:0]    good_next;
   logic [ERR_W-1:0] err_next;

   assign rise        = div_in & ~div_d_reg;
   assign active      = en && (state_reg == MEASURE || state_reg == LOCKED);
   assign period_end  = active && rise;
   assign timeout     = active && !rise && (cnt_reg == TWO_N);
   assign start       = en && rise && (state_reg != IDLE);
   assign good_period = (cnt_reg == N_C) && duty_ok;
   assign good_next   = (good_reg >= LOCK_C) ? good_reg : good_reg + GW'(1);
   assign err_next    = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);

`ifdef DIV_MON_DUTY_CHECK_EN
   logic [CNT_W-1:0] hcnt_reg;

   // Either N/2 or (N+1)/2 high samples is a 50% duty clock seen on one edge.
   assign duty_ok = (hcnt_reg == CNT_W'(N / 2)) || (hcnt_reg == CNT_W'((N + 1) / 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_reg <= '0;
         high_cnt <= '0;
      end else begin
         if (period_end || timeout)
            high_cnt <= hcnt_reg;
         if (start)
            hcnt_reg <= CNT_ONE;
         else if (active && !timeout)
            hcnt_reg <= hcnt_reg + {{(CNT_W-1){1'b0}}, div_in};
         else
            hcnt_reg <= '0;
      end
   end
`else
   assign duty_ok  = 1'b1;
   assign high_cnt = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         div_d_reg    <= 1'b0;
         cnt_reg      <= '0;
         good_reg     <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         lock_lost    <= 1'b0;
         err_cnt      <= '0;
      end else begin
         div_d_reg    <= div_in;
         period_valid <= 1'b0;
         // Disabling wins over any rise or timeout sampled in the same cycle.
         if (!en) begin
            state_reg <= IDLE;
            locked    <= 1'b0;
            cnt_reg   <= '0;
            good_reg  <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  cnt_reg   <= '0;
                  good_reg  <= '0;
                  state_reg <= SYNC;
               end
               SYNC: begin
                  if (rise) begin
                     cnt_reg   <= CNT_ONE;
                     state_reg <= MEASURE;
                  end
               end
               MEASURE, LOCKED: begin
                  if (rise) begin
                     period_valid <= 1'b1;
                     period       <= cnt_reg;
                     cnt_reg      <= CNT_ONE;
                     if (good_period) begin
                        good_reg <= good_next;
                        if (good_next == LOCK_C) begin
                           locked    <= 1'b1;
                           state_reg <= LOCKED;
                        end
                     end else begin
                        good_reg <= '0;
                        err_cnt  <= err_next;
                        if (state_reg == LOCKED) begin
                           locked    <= 1'b0;
                           lock_lost <= 1'b1;
                           state_reg <= MEASURE;
                        end
                     end
                  end else if (timeout) begin
                     period_valid <= 1'b1;
                     period       <= '0;
                     cnt_reg      <= '0;
                     good_reg     <= '0;
                     err_cnt      <= err_next;
                     locked       <= 1'b0;
                     if (locked)
                        lock_lost <= 1'b1;
                     state_reg <= SYNC;
                  end else begin
                     cnt_reg <= cnt_reg + CNT_ONE;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_monitor.sv
// Scoreboard bench for div_monitor: N=3 instance (u=0) and N=5 instance (u=1).
module tb_div_monitor;

`ifdef DIV_MON_DUTY_CHECK_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   typedef struct {
      int u;
      int per;
      int hi;
      int lk;
      int ll;
      int err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_i [2];
   logic       en_i  [2];
   logic       din   [2];
   logic [7:0] per_o [2];
   logic [7:0] hi_o  [2];
   logic [7:0] err_o [2];
   logic       pv    [2];
   logic       lk    [2];
   logic       ll    [2];

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   div_monitor #(.N(3), .CNT_W(8), .LOCK_CNT(4), .ERR_W(8)) dut3 (
      .clk(clk), .rst(rst_i[0]), .en(en_i[0]), .div_in(din[0]),
      .period(per_o[0]), .high_cnt(hi_o[0]), .period_valid(pv[0]),
      .locked(lk[0]), .lock_lost(ll[0]), .err_cnt(err_o[0])
   );

   div_monitor #(.N(5), .CNT_W(8), .LOCK_CNT(4), .ERR_W(8)) dut5 (
      .clk(clk), .rst(rst_i[1]), .en(en_i[1]), .div_in(din[1]),
      .period(per_o[1]), .high_cnt(hi_o[1]), .period_valid(pv[1]),
      .locked(lk[1]), .lock_lost(ll[1]), .err_cnt(err_o[1])
   );

   function automatic int hx(int h);
      return DUTY ? h : 0;
   endfunction

   task automatic ex(int u, int per, int hi, int lkv, int llv, int err);
      exp_t e;
      e.u = u; e.per = per; e.hi = hi; e.lk = lkv; e.ll = llv; e.err = err;
      sb.push_back(e);
   endtask

   task automatic chk(string nm, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic drv(int u, bit v);
      @(negedge clk);
      din[u] = v;
   endtask

   task automatic per(int u, int len, int hi);
      for (int i = 0; i < len; i++)
         drv(u, i < hi);
   endtask

   task automatic drain(string nm);
      for (int i = 0; i < 40 && sb.size() != 0; i++)
         @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected period_valid pulses never arrived", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic chk_zero(string nm, int u);
      chk({nm, " period"}, per_o[u], 0);
      chk({nm, " high_cnt"}, hi_o[u], 0);
      chk({nm, " period_valid"}, pv[u], 0);
      chk({nm, " locked"}, lk[u], 0);
      chk({nm, " lock_lost"}, ll[u], 0);
      chk({nm, " err_cnt"}, err_o[u], 0);
   endtask

   // Monitor: every period_valid pulse must match the head of the scoreboard.
   always begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         if (pv[u]) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid u%0d: period %0d high %0d err %0d, none expected",
                        u, per_o[u], hi_o[u], err_o[u]);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.u != u || per_o[u] != e.per || hi_o[u] != e.hi || lk[u] != e.lk ||
                   ll[u] != e.ll || err_o[u] != e.err) begin
                  errors++;
                  $display("FAIL valid u%0d: got per=%0d hi=%0d lk=%0d ll=%0d err=%0d expected u%0d per=%0d hi=%0d lk=%0d ll=%0d err=%0d",
                           u, per_o[u], hi_o[u], lk[u], ll[u], err_o[u],
                           e.u, e.per, e.hi, e.lk, e.ll, e.err);
               end else begin
                  $display("valid u%0d per=%0d hi=%0d lk=%0d ll=%0d err=%0d ok",
                           u, per_o[u], hi_o[u], lk[u], ll[u], err_o[u]);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst_i[u] = 1'b1;
         en_i[u]  = 1'b0;
         din[u]   = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk_zero("reset u0", 0);
      chk_zero("reset u1", 1);
      rst_i[0] = 1'b0;
      rst_i[1] = 1'b0;

      // N=3, pattern 1,1,0: lock on the 4th valid.
      en_i[0] = 1'b1;
      drv(0, 0);
      for (int k = 1; k <= 6; k++) ex(0, 3, hx(2), k >= 4, 0, 0);
      repeat (6) per(0, 3, 2);
      drv(0, 1);
      drain("t1 n3 lock");
      chk("t1 locked", lk[0], 1);

      // Timeout after the last rise, then relock.
      ex(0, 0, hx(1), 0, 1, 1);
      repeat (8) drv(0, 0);
      drain("t3 timeout");
      chk("t3 locked after timeout", lk[0], 0);
      for (int k = 1; k <= 4; k++) ex(0, 3, hx(2), k == 4, 1, 1);
      repeat (4) per(0, 3, 2);
      drv(0, 1);
      drain("t3 relock");

      // Async reset mid-period while locked.
      drv(0, 1);
      @(negedge clk);
      #2 rst_i[0] = 1'b1;
      #1 chk_zero("t5 async reset", 0);
      @(negedge clk);
      rst_i[0] = 1'b0;
      din[0]   = 1'b0;
      for (int k = 1; k <= 4; k++) ex(0, 3, hx(2), k == 4, 0, 0);
      repeat (4) per(0, 3, 2);
      drv(0, 1);
      drain("t5 after reset");

      // en dropped for 3 cycles, first cycle coincides with a rise.
      drv(0, 1);
      drv(0, 0);
      @(negedge clk);
      en_i[0] = 1'b0;
      din[0]  = 1'b1;
      drv(0, 1);
      drv(0, 0);
      @(negedge clk);
      chk("t6 locked with en=0", lk[0], 0);
      chk("t6 err_cnt held", err_o[0], 0);
      chk("t6 lock_lost held", ll[0], 0);
      chk("t6 period held", per_o[0], 3);
      en_i[0] = 1'b1;
      din[0]  = 1'b0;
      for (int k = 1; k <= 4; k++) ex(0, 3, hx(2), k == 4, 0, 0);
      repeat (4) per(0, 3, 2);
      drv(0, 1);
      drain("t6 relock");

      // 300 timeouts: err_cnt saturates at 255.
      for (int k = 1; k <= 300; k++) ex(0, 0, hx(1), 0, 1, (k > 255) ? 255 : k);
      repeat (6) drv(0, 0);
      repeat (299) begin
         drv(0, 1);
         repeat (6) drv(0, 0);
      end
      drain("t6 saturation");
      chk("t6 err_cnt saturated", err_o[0], 255);

      // N=5, pattern 1,1,0,0,0 with one short period after lock.
      en_i[1] = 1'b1;
      drv(1, 0);
      for (int k = 1; k <= 4; k++) ex(1, 5, hx(2), k == 4, 0, 0);
      ex(1, 4, hx(2), 0, 1, 1);
      for (int k = 1; k <= 4; k++) ex(1, 5, hx(2), k == 4, 1, 1);
      repeat (4) per(1, 5, 2);
      per(1, 4, 2);
      repeat (4) per(1, 5, 2);
      drv(1, 1);
      drain("t2 n5 short period");
      chk("t2 lock_lost sticky", ll[1], 1);

      // N=5, pattern 1,1,1,1,0: bad duty only when duty checking is built in.
      @(negedge clk);
      rst_i[1] = 1'b1;
      din[1]   = 1'b0;
      @(negedge clk);
      rst_i[1] = 1'b0;
      drv(1, 0);
      for (int k = 1; k <= 5; k++) ex(1, 5, hx(4), DUTY ? 0 : (k >= 4), 0, DUTY ? k : 0);
      repeat (5) per(1, 5, 4);
      drv(1, 1);
      drain("t4 duty");
      chk("t4 lock_lost", ll[1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
